// File: rtl/score_keeper.sv
// Score keeper for the driving game: frame-tick timing, IDLE/RUN/CRASH
// sequencing, 4-digit BCD score with saturation, high score and crash blink.
module score_keeper #(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned HOLD_FRAMES      = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        deadFlag,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [1:0]  state,
  output logic        playing,
  output logic [15:0] score_bcd,
  output logic [15:0] hiscore_bcd,
  output logic        new_hi,
  output logic        flash
);

  localparam int unsigned FW = 6;
  localparam int unsigned HW = 8;
  localparam int unsigned SW = 16;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_CRASH = 2'b10;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_POINT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [SW-1:0] SCORE_MAX  = 16'h9999;

  logic [1:0]    r_state;
  logic          r_playing;
  logic [SW-1:0] r_score;
  logic [SW-1:0] r_hiscore;
  logic          r_new_hi;
  logic          r_flash;
  logic [FW-1:0] r_fcnt;
  logic [HW-1:0] r_hcnt;
  logic          r_fz;
  logic          r_fz_prev;
  logic          r_start_q;

  logic          w_tick;
  logic          w_start_rise;
  logic [1:0]    w_state_d;
  logic [SW-1:0] w_score_d;
  logic [SW-1:0] w_hiscore_d;
  logic          w_new_hi_d;
  logic [FW-1:0] w_fcnt_d;
  logic [HW-1:0] w_hcnt_d;
  logic          w_playing_d;
  logic          w_flash_d;

  // BCD +1 with per-digit carry; 9999 stays 9999
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    if (v != SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // One tick per frame and one pulse per button press
  assign w_tick       = r_fz && !r_fz_prev;
  assign w_start_rise = start && !r_start_q;

  // Next-state and next-output logic
  always_comb begin
    w_state_d   = r_state;
    w_score_d   = r_score;
    w_hiscore_d = r_hiscore;
    w_new_hi_d  = 1'b0;
    w_fcnt_d    = r_fcnt;
    w_hcnt_d    = r_hcnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_d = S_RUN;
          w_score_d = '0;
          w_fcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (deadFlag) begin
          w_state_d = S_CRASH;
          w_hcnt_d  = '0;
          if (r_score > r_hiscore) begin
            w_hiscore_d = r_score;
            w_new_hi_d  = 1'b1;
          end
        end else if (w_tick) begin
          if (r_fcnt == FRAME_LAST) begin
            w_fcnt_d  = '0;
            w_score_d = bcd_inc(r_score);
          end else begin
            w_fcnt_d = r_fcnt + FW'(1);
          end
        end
      end
      S_CRASH: begin
        if (w_tick) begin
          if (r_hcnt == HOLD_LAST) begin
            w_state_d = S_IDLE;
          end else begin
            w_hcnt_d = r_hcnt + HW'(1);
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase
    w_playing_d = (w_state_d == S_RUN);
    w_flash_d   = (w_state_d == S_CRASH) && w_hcnt_d[3];
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_playing <= 1'b0;
      r_score   <= '0;
      r_hiscore <= '0;
      r_new_hi  <= 1'b0;
      r_flash   <= 1'b0;
      r_fcnt    <= '0;
      r_hcnt    <= '0;
      r_fz      <= 1'b0;
      r_fz_prev <= 1'b0;
      // Track the button level through reset so a held button must be
      // released and pressed again before a game can start.
      r_start_q <= start;
    end else begin
      r_state   <= w_state_d;
      r_playing <= w_playing_d;
      r_score   <= w_score_d;
      r_hiscore <= w_hiscore_d;
      r_new_hi  <= w_new_hi_d;
      r_flash   <= w_flash_d;
      r_fcnt    <= w_fcnt_d;
      r_hcnt    <= w_hcnt_d;
      r_fz      <= (hCount == 10'd0) && (vCount == 10'd0);
      r_fz_prev <= r_fz;
      r_start_q <= start;
    end
  end

  assign state       = r_state;
  assign playing     = r_playing;
  assign score_bcd   = r_score;
  assign hiscore_bcd = r_hiscore;
  assign new_hi      = r_new_hi;
  assign flash       = r_flash;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (default and fast parameters)
// share one stimulus and are compared every cycle against a decimal model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dead;
  logic [9:0]  hc;
  logic [9:0]  vc;

  logic [1:0]  a_state, b_state;
  logic        a_playing, b_playing;
  logic [15:0] a_score, b_score;
  logic [15:0] a_hi, b_hi;
  logic        a_new_hi, b_new_hi;
  logic        a_flash, b_flash;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  score_keeper #(.FRAMES_PER_POINT(6), .HOLD_FRAMES(120)) u_dut (
    .clk(clk), .rst(rst), .start(start), .deadFlag(dead),
    .hCount(hc), .vCount(vc),
    .state(a_state), .playing(a_playing), .score_bcd(a_score),
    .hiscore_bcd(a_hi), .new_hi(a_new_hi), .flash(a_flash)
  );

  score_keeper #(.FRAMES_PER_POINT(1), .HOLD_FRAMES(3)) u_fast (
    .clk(clk), .rst(rst), .start(start), .deadFlag(dead),
    .hCount(hc), .vCount(vc),
    .state(b_state), .playing(b_playing), .score_bcd(b_score),
    .hiscore_bcd(b_hi), .new_hi(b_new_hi), .flash(b_flash)
  );

  // Game model: state 0/1/2, scores as plain decimal integers
  typedef struct packed {
    int   st;
    int   score;
    int   hi;
    int   frames;
    int   hold;
    logic new_hi;
    logic fz;
    logic fzp;
    logic start_q;
  } model_t;

  model_t ma = '0;
  model_t mb = '0;

  function automatic model_t step(input model_t m, input int fpp, input int hold_n,
                                  input logic rst_n, input logic st_in, input logic dead_in,
                                  input logic zero);
    model_t n;
    logic   tick;
    logic   rise;
    n         = m;
    tick      = m.fz && !m.fzp;
    rise      = st_in && !m.start_q;
    n.fzp     = m.fz;
    n.fz      = zero;
    n.start_q = st_in;
    n.new_hi  = 1'b0;
    if (!rst_n) begin
      n.st = 0; n.score = 0; n.hi = 0; n.frames = 0; n.hold = 0;
      n.fz = 1'b0; n.fzp = 1'b0;
      return n;
    end
    case (m.st)
      0: if (rise) begin
        n.st = 1; n.score = 0; n.frames = 0;
      end
      1: if (dead_in) begin
        n.st = 2; n.hold = 0;
        if (m.score > m.hi) begin
          n.hi = m.score; n.new_hi = 1'b1;
        end
      end else if (tick) begin
        n.frames = m.frames + 1;
        if (n.frames == fpp) begin
          n.frames = 0;
          if (m.score < 9999) n.score = m.score + 1;
        end
      end
      default: if (tick) begin
        n.hold = m.hold + 1;
        if (n.hold == hold_n) n.st = 0;
      end
    endcase
    return n;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int flash_of(input model_t m);
    return (m.st == 2 && ((m.hold / 8) % 2) == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge as the DUTs
  always @(posedge clk) begin
    ma <= step(ma, 6, 120, rst, start, dead, (hc == 10'd0) && (vc == 10'd0));
    mb <= step(mb, 1, 3,   rst, start, dead, (hc == 10'd0) && (vc == 10'd0));
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.state",   int'(a_state),   ma.st);
      chk("a.playing", int'(a_playing), (ma.st == 1) ? 1 : 0);
      chk("a.score",   int'(a_score),   to_bcd(ma.score));
      chk("a.hiscore", int'(a_hi),      to_bcd(ma.hi));
      chk("a.new_hi",  int'(a_new_hi),  int'(ma.new_hi));
      chk("a.flash",   int'(a_flash),   flash_of(ma));
      chk("b.state",   int'(b_state),   mb.st);
      chk("b.playing", int'(b_playing), (mb.st == 1) ? 1 : 0);
      chk("b.score",   int'(b_score),   to_bcd(mb.score));
      chk("b.hiscore", int'(b_hi),      to_bcd(mb.hi));
      chk("b.new_hi",  int'(b_new_hi),  int'(mb.new_hi));
      chk("b.flash",   int'(b_flash),   flash_of(mb));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_nonzero();
    if ($urandom_range(0, 2) == 0) begin
      hc = 10'd0;
      vc = 10'($urandom_range(1, 1023));
    end else begin
      hc = 10'($urandom_range(1, 1023));
      vc = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      hc = 10'd0;
      vc = 10'd0;
      cyc();
      set_nonzero();
      repeat ($urandom_range(1, 2)) cyc();
    end
  endtask

  task automatic press();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    dead  = 1'b0;
    hc    = 10'd5;
    vc    = 10'd5;
    cyc();
    chk_en = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    // Held start through reset release must not start a game
    repeat (4) cyc();
    @(negedge clk);
    chk("held_start_idle", int'(a_state), 0);
    chk("reset_score", int'(a_score), 0);

    // Idle start and 60 frames
    press();
    @(negedge clk);
    chk("start_run", int'(a_state), 1);
    frames(60);
    @(negedge clk);
    chk("run60_state", int'(a_state), 1);
    chk("run60_playing", int'(a_playing), 1);
    chk("run60_score", int'(a_score), 'h0010);
    chk("fast60_score", int'(b_score), 'h0060);

    // Reach 42 then crash
    frames(192);
    @(negedge clk);
    chk("score42", int'(a_score), 'h0042);
    chk("model42", ma.score, 42);
    dead = 1'b1;
    cyc();
    dead = 1'b0;
    @(negedge clk);
    chk("crash_state", int'(a_state), 2);
    chk("crash_hi", int'(a_hi), 'h0042);
    chk("crash_new_hi", int'(a_new_hi), 1);
    chk("crash_playing", int'(a_playing), 0);
    cyc();
    @(negedge clk);
    chk("new_hi_one_cycle", int'(a_new_hi), 0);

    // Hold timing, blink and ignored start in CRASH
    frames(8);
    @(negedge clk);
    chk("flash_on", int'(a_flash), 1);
    press();
    @(negedge clk);
    chk("start_in_crash", int'(a_state), 2);
    frames(8);
    @(negedge clk);
    chk("flash_off", int'(a_flash), 0);
    frames(103);
    @(negedge clk);
    chk("hold119_state", int'(a_state), 2);
    frames(1);
    @(negedge clk);
    chk("hold120_idle", int'(a_state), 0);
    chk("idle_keeps_score", int'(a_score), 'h0042);

    // Second game: collision on a scoring tick at 0030
    press();
    frames(185);
    hc = 10'd0;
    vc = 10'd0;
    cyc();
    set_nonzero();
    dead = 1'b1;
    cyc();
    dead = 1'b0;
    @(negedge clk);
    chk("collide_score", int'(a_score), 'h0030);
    chk("collide_state", int'(a_state), 2);
    chk("second_hi", int'(a_hi), 'h0042);
    chk("second_no_new_hi", int'(a_new_hi), 0);
    frames(120);

    // Reset in the middle of a run
    press();
    frames(102);
    @(negedge clk);
    chk("score17", int'(a_score), 'h0017);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(a_state), 0);
    chk("rst_playing", int'(a_playing), 0);
    chk("rst_score", int'(a_score), 0);
    chk("rst_hi", int'(a_hi), 0);
    chk("rst_new_hi", int'(a_new_hi), 0);
    chk("rst_flash", int'(a_flash), 0);

    // Carry and saturation on the one-frame-per-point instance
    press();
    frames(999);
    @(negedge clk);
    chk("fast_0999", int'(b_score), 'h0999);
    frames(1);
    @(negedge clk);
    chk("fast_carry_1000", int'(b_score), 'h1000);
    frames(9002);
    @(negedge clk);
    chk("fast_sat_9999", int'(b_score), 'h9999);
    chk("fast_sat_state", int'(b_state), 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) start = ~start;
      dead = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        hc = 10'd0;
        vc = 10'd0;
      end else begin
        set_nonzero();
      end
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst  = 1'b1;
    dead = 1'b0;
    cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
